// File: rtl/signal_reconstructor.sv
// rtl/signal_reconstructor.sv - replays buffered (time, data) events onto dataOut against a playback counter
// Option macro SIGNAL_RECONSTRUCTOR_LATE_DROP_EN: discard late events instead of applying them.
module signal_reconstructor #(
  parameter int DATA_W     = 8,
  parameter int TIME_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] dataTime,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              newData,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] dataOut,
  output logic              changed,
  output logic [TIME_W-1:0] playTime,
  output logic              empty,
  output logic              overflow,
  output logic              late
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state;
  logic [TIME_W-1:0]     mem_time [DEPTH];
  logic [DATA_W-1:0]     mem_data [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [TIME_W-1:0]     head_time;
  logic [DATA_W-1:0]     head_data;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  head_late;

  assign empty = (count == '0);

  always_comb begin
    head_time = mem_time[rd_ptr];
    head_data = mem_data[rd_ptr];
    full      = (count == DEPTH_CNT);
    head_late = (head_time < playTime);
    // A restart edge never pops; the head is re-evaluated against the cleared counter.
    pop       = (state == RUN) && !start && !empty && (head_time <= playTime);
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    push      = newData && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr] <= dataTime;
      mem_data[wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      playTime <= '0;
      dataOut  <= '0;
      changed  <= 1'b0;
      overflow <= 1'b0;
      late     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            playTime <= '0;
          end
        end
        default: begin
          if (start) begin
            playTime <= '0;
          end else begin
            playTime <= playTime + 1'b1;
            if (stop) state <= IDLE;
          end
        end
      endcase

      changed <= 1'b0;
      if (pop) begin
`ifdef SIGNAL_RECONSTRUCTOR_LATE_DROP_EN
        if (head_late) begin
          late <= 1'b1;
        end else begin
          dataOut <= head_data;
          changed <= 1'b1;
        end
`else
        dataOut <= head_data;
        changed <= 1'b1;
        if (head_late) late <= 1'b1;
`endif
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (newData && !push) overflow <= 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
